// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8-bit UART transmitter with valid/ready byte handshake.
//             Frame = start bit, 8 data bits LSB first, optional parity bit,
//             one or two stop bits. Each bit lasts CLKS_PER_BIT clocks.
//
//  Parameters
//    CLKS_PER_BIT : clocks per serial bit (2..65535)
//    PARITY_EN    : 1 = append a parity bit after the data bits
//    PARITY_ODD   : 0 = even parity, 1 = odd parity (only if PARITY_EN=1)
//    STOP_BITS    : 1 or 2 stop bits
//
//  Ports
//    clk      : in  - clock, rising edge
//    RST      : in  - asynchronous active-high reset
//    tx_valid : in  - tx_data holds a byte to send
//    tx_data  : in  - byte to send, sampled at handshake only
//    tx_ready : out - block accepts a byte this cycle (IDLE)
//    tx_out   : out - serial line, idle/mark = 1
//    tx_busy  : out - frame in progress (NOT tx_ready)
//    tx_done  : out - one-cycle pulse on the first IDLE cycle after STOP
//
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                 c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic               c_PAR_EN    = (PARITY_EN != 0);
    localparam logic               c_PAR_ODD   = (PARITY_ODD != 0);
    localparam logic [2:0]         c_IDX_LAST  = 3'd7;
    // r_idx doubles as the stop-bit index while in STOP
    localparam logic [2:0]         c_STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_tx_out;
    logic               r_tx_done;

    logic               w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_LAST);

    assign tx_ready = (r_state == c_ST_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_out   = r_tx_out;
    assign tx_done  = r_tx_done;

    // tx_out is registered one state ahead: the value for the next bit is
    // loaded on the same edge that moves the FSM into that bit, so the line
    // changes exactly at bit boundaries without any combinational decode.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx_out  <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_tx_out <= 1'b1;
                    r_cnt    <= '0;
                    r_idx    <= '0;
                    if (tx_valid) begin
                        r_shift  <= tx_data;
                        // parity is captured up front because the shift
                        // register is consumed while sending the data bits
                        r_parity <= (^tx_data) ^ c_PAR_ODD;
                        r_tx_out <= 1'b0;
                        r_state  <= c_ST_START;
                    end
                end

                c_ST_START: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_tx_out <= r_shift[0];
                        r_state  <= c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_idx <= '0;
                            if (c_PAR_EN) begin
                                r_tx_out <= r_parity;
                                r_state  <= c_ST_PARITY;
                            end else begin
                                r_tx_out <= 1'b1;
                                r_state  <= c_ST_STOP;
                            end
                        end else begin
                            r_idx    <= r_idx + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx_out <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_tx_out <= 1'b1;
                        r_state  <= c_ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_STOP: begin
                    r_tx_out <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == c_STOP_LAST) begin
                            r_idx     <= '0;
                            r_tx_done <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    // unreachable encodings recover to a clean idle line
                    r_state  <= c_ST_IDLE;
                    r_cnt    <= '0;
                    r_idx    <= '0;
                    r_tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx. Four instances cover the
//             parameter corners (plain, even parity, odd parity + 2 stop,
//             CLKS_PER_BIT=2). Expected waveforms come from a per-cycle
//             line model built from the frame rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB [4] = '{4, 4, 4, 2};
    localparam int PEN [4] = '{0, 1, 1, 0};
    localparam int POD [4] = '{0, 0, 1, 0};
    localparam int STB [4] = '{1, 1, 2, 1};

    logic       clk;
    logic       RST;
    logic       valid_v [4];
    logic [7:0] data_v  [4];
    logic       out_v   [4];
    logic       ready_v [4];
    logic       busy_v  [4];
    logic       done_v  [4];

    int errors;
    int checks;

    bit cap_out [$];
    bit cap_done [$];
    bit cap_ready [$];
    bit exp_out [$];
    bit exp_done [$];
    bit exp_ready [$];

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .RST(RST), .tx_valid(valid_v[0]), .tx_data(data_v[0]),
        .tx_ready(ready_v[0]), .tx_out(out_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .RST(RST), .tx_valid(valid_v[1]), .tx_data(data_v[1]),
        .tx_ready(ready_v[1]), .tx_out(out_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .RST(RST), .tx_valid(valid_v[2]), .tx_data(data_v[2]),
        .tx_ready(ready_v[2]), .tx_out(out_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut3 (
        .clk(clk), .RST(RST), .tx_valid(valid_v[3]), .tx_data(data_v[3]),
        .tx_ready(ready_v[3]), .tx_out(out_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int frame_len(input int k);
        return (1 + 8 + PEN[k] + STB[k]) * CPB[k];
    endfunction

    function automatic void clear_model();
        exp_out.delete(); exp_done.delete(); exp_ready.delete();
    endfunction

    // Appends one frame, cycle by cycle from the first cycle after the
    // handshake edge, followed by the tx_done cycle and optionally one idle.
    function automatic void model_append(input int k, input logic [7:0] d, input bit tail);
        bit line [$];
        line.push_back(1'b0);
        for (int b = 0; b < 8; b++) line.push_back(d[b]);
        if (PEN[k] != 0) line.push_back((^d) ^ (POD[k] != 0));
        for (int s = 0; s < STB[k]; s++) line.push_back(1'b1);
        foreach (line[i]) begin
            for (int c = 0; c < CPB[k]; c++) begin
                exp_out.push_back(line[i]); exp_done.push_back(1'b0); exp_ready.push_back(1'b0);
            end
        end
        exp_out.push_back(1'b1); exp_done.push_back(1'b1); exp_ready.push_back(1'b1);
        if (tail) begin
            exp_out.push_back(1'b1); exp_done.push_back(1'b0); exp_ready.push_back(1'b1);
        end
    endfunction

    function automatic void model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_out.push_back(1'b1); exp_done.push_back(1'b0); exp_ready.push_back(1'b1);
        end
    endfunction

    function automatic int first_diff();
        if (cap_out.size() != exp_out.size()) return 0;
        foreach (exp_out[i])
            if (cap_out[i] != exp_out[i] || cap_done[i] != exp_done[i] || cap_ready[i] != exp_ready[i])
                return i;
        return -1;
    endfunction

    function automatic int done_index();
        foreach (cap_done[i]) if (cap_done[i]) return i;
        return -1;
    endfunction

    // ---------------- stimulus / capture ----------------
    task automatic sample(input int k);
        @(negedge clk);
        cap_out.push_back(out_v[k]);
        cap_done.push_back(done_v[k]);
        cap_ready.push_back(ready_v[k]);
    endtask

    // Offers a byte, waits (bounded) for the handshake, scrambles tx_data
    // right after it, then records n cycles of the line.
    task automatic capture(input int k, input logic [7:0] d, input int n, output bit ok);
        int t;
        ok = 1'b1;
        cap_out.delete(); cap_done.delete(); cap_ready.delete();
        valid_v[k] = 1'b1;
        data_v[k]  = d;
        t = 0;
        while (ready_v[k] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ready_v[k] !== 1'b1) begin
            ok = 1'b0;
            valid_v[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid_v[k] = 1'b0;
        data_v[k]  = 8'($urandom);
        for (int i = 0; i < n; i++) sample(k);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_v[k], ready_v[k], busy_v[k], done_v[k]} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_async k=%0d: out/ready/busy/done=%b, want 1100", k,
                         {out_v[k], ready_v[k], busy_v[k], done_v[k]});
            end
        end
        @(negedge clk);
        RST = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_v[k], ready_v[k], busy_v[k], done_v[k]} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_idle k=%0d: out/ready/busy/done=%b, want 1100", k,
                         {out_v[k], ready_v[k], busy_v[k], done_v[k]});
            end
        end
    endtask

    task automatic test_frame_a5();
        bit ok;
        int fd, bad;
        bit spec_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        clear_model();
        model_append(0, 8'hA5, 1'b1);
        capture(0, 8'hA5, exp_out.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL a5_handshake: no tx_ready within budget, want handshake");
            return;
        end
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL a5_frame: differs at cycle %0d got out=%b want %b", fd, cap_out[fd], exp_out[fd]);
        end
        bad = 0;
        for (int b = 0; b < 10; b++)
            for (int j = 0; j < 4; j++)
                if (cap_out[b*4+j] != spec_bits[b]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL a5_bits: %0d wrong line cycles, want 0", bad);
        end
        checks++;
        if (done_index() != 40) begin
            errors++;
            $display("FAIL a5_done_time: tx_done at cycle %0d, want 40", done_index());
        end
    endtask

    task automatic test_parity();
        bit ok;
        int fd, bad;
        for (int k = 1; k <= 2; k++) begin
            clear_model();
            model_append(k, 8'hA5, 1'b1);
            capture(k, 8'hA5, exp_out.size(), ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL parity_handshake k=%0d: no tx_ready, want handshake", k);
                continue;
            end
            fd = first_diff();
            checks++;
            if (fd != -1) begin
                errors++;
                $display("FAIL parity_frame k=%0d: differs at cycle %0d got out=%b want %b", k, fd,
                         cap_out[fd], exp_out[fd]);
            end
            // 0xA5 has four ones: even parity bit 0, odd parity bit 1
            bad = 0;
            for (int i = 36; i < 40; i++) if (cap_out[i] != (k == 2)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL parity_bit k=%0d: %0d wrong cycles, want parity=%0d", k, bad, (k == 2));
            end
        end
        // two stop bits: 8 mark cycles, tx_done at 48
        bad = 0;
        for (int i = 40; i < 48; i++) if (cap_out[i] != 1'b1 || cap_done[i]) bad++;
        checks++;
        if (bad != 0 || done_index() != 48) begin
            errors++;
            $display("FAIL stop2: bad=%0d done at %0d, want bad=0 done at 48", bad, done_index());
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        int fd;
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 3; r++) begin
                d = 8'($urandom);
                clear_model();
                model_append(k, d, 1'b1);
                capture(k, d, exp_out.size(), ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL random_handshake k=%0d: no tx_ready, want handshake", k);
                    continue;
                end
                fd = first_diff();
                checks++;
                if (fd != -1) begin
                    errors++;
                    $display("FAIL random_frame k=%0d data=%h: differs at cycle %0d got out=%b done=%b want out=%b done=%b",
                             k, d, fd, cap_out[fd], cap_done[fd], exp_out[fd], exp_done[fd]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t, fd, run, len;
        len = frame_len(0);
        clear_model();
        model_append(0, 8'h00, 1'b0);
        model_append(0, 8'hFF, 1'b1);
        cap_out.delete(); cap_done.delete(); cap_ready.delete();
        valid_v[0] = 1'b1;
        data_v[0]  = 8'h00;
        t = 0;
        while (ready_v[0] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ready_v[0] !== 1'b1) begin
            errors++;
            valid_v[0] = 1'b0;
            $display("FAIL b2b_handshake: tx_ready=%b, want 1", ready_v[0]);
            return;
        end
        @(posedge clk);
        #1;
        data_v[0] = 8'hFF;
        for (int i = 0; i < exp_out.size(); i++) begin
            sample(0);
            if (i == len) begin
                @(posedge clk);
                #1;
                valid_v[0] = 1'b0;
            end
        end
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL b2b_frames: differs at cycle %0d got out=%b ready=%b want out=%b ready=%b",
                     fd, cap_out[fd], cap_ready[fd], exp_out[fd], exp_ready[fd]);
        end
        run = 0;
        for (int i = len; i >= 0 && cap_out[i]; i--) run++;
        checks++;
        if (run != 5 || cap_out[len+1] != 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: %0d mark cycles then out=%b, want 5 then 0", run, cap_out[len+1]);
        end
    endtask

    task automatic test_ignore_busy();
        bit ok;
        int fd, pulses;
        logic [7:0] d;
        d = 8'($urandom);
        clear_model();
        model_append(0, d, 1'b1);
        model_idle(2 * CPB[0]);
        cap_out.delete(); cap_done.delete(); cap_ready.delete();
        valid_v[0] = 1'b1;
        data_v[0]  = d;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (ready_v[0] === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            valid_v[0] = 1'b0;
            $display("FAIL busy_handshake: no tx_ready, want handshake");
            return;
        end
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        for (int i = 0; i < exp_out.size(); i++) begin
            sample(0);
            if (i == 10) begin valid_v[0] = 1'b1; data_v[0] = 8'h3C; end
            if (i == 13) begin valid_v[0] = 1'b0; data_v[0] = 8'($urandom); end
        end
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL busy_frame data=%h: differs at cycle %0d got out=%b ready=%b want out=%b ready=%b",
                     d, fd, cap_out[fd], cap_ready[fd], exp_out[fd], exp_ready[fd]);
        end
        pulses = 0;
        foreach (cap_done[i]) if (cap_done[i]) pulses++;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL busy_single_frame: %0d tx_done pulses, want 1", pulses);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int fd, bad;
        logic [7:0] d;
        d = 8'($urandom);
        valid_v[0] = 1'b1;
        data_v[0]  = d;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (ready_v[0] === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            valid_v[0] = 1'b0;
            $display("FAIL rst_handshake: no tx_ready, want handshake");
            return;
        end
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        // data bit 3 occupies cycles 16..19 after the handshake
        for (int i = 0; i <= 17; i++) @(negedge clk);
        RST = 1'b1;
        #1;
        checks++;
        if ({out_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_async: out/ready/busy/done=%b, want 1100",
                     {out_v[0], ready_v[0], busy_v[0], done_v[0]});
        end
        repeat (2) @(negedge clk);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || out_v[0] !== 1'b1 || ready_v[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_resume: %0d non-idle cycles after reset, want 0", bad);
        end
        clear_model();
        model_append(0, 8'h81, 1'b1);
        capture(0, 8'h81, exp_out.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_resend_handshake: no tx_ready, want handshake");
            return;
        end
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL rst_resend_frame: differs at cycle %0d got out=%b want %b", fd, cap_out[fd], exp_out[fd]);
        end
    endtask

    task automatic test_min_clks();
        bit ok;
        int fd;
        clear_model();
        model_append(3, 8'hA5, 1'b1);
        capture(3, 8'hA5, exp_out.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL min_handshake: no tx_ready, want handshake");
            return;
        end
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL min_frame: differs at cycle %0d got out=%b want %b", fd, cap_out[fd], exp_out[fd]);
        end
        checks++;
        if (done_index() != 20) begin
            errors++;
            $display("FAIL min_done_time: tx_done at cycle %0d, want 20", done_index());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid_v[k] = 1'b0;
            data_v[k]  = 8'h00;
        end
        #1;
        RST = 1'b1;
        test_reset();
        test_frame_a5();
        test_parity();
        test_random_frames();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
        test_min_clks();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts one parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port RST, input, 1: asynchronous, active-high reset.
REQ-007 Port tx_valid, input, 1: tx_data holds a byte to send.
REQ-008 Port tx_data, input, 8: byte to transmit; sampled only at handshake.
REQ-009 Port tx_ready, output, 1: block accepts a byte this cycle.
REQ-010 Port tx_out, output, 1: serial line; idle/mark level is 1.
REQ-011 Port tx_busy, output, 1: a frame is in progress.
REQ-012 Port tx_done, output, 1: single-cycle pulse at frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; every output SHALL be registered or decoded from state only.
REQ-014 tx_ready SHALL be 1 exactly when in IDLE; tx_busy SHALL equal NOT tx_ready.
REQ-015 Handshake: tx_valid=1 and tx_ready=1 at a rising edge SHALL latch tx_data into an internal shift register and move IDLE->START.
REQ-016 tx_valid while tx_ready=0 SHALL be ignored; tx_data changes after handshake SHALL NOT affect the frame.
REQ-017 START SHALL drive tx_out=0 for CLKS_PER_BIT cycles, beginning the cycle after handshake.
REQ-018 DATA SHALL drive 8 bits LSB first, each held CLKS_PER_BIT cycles.
REQ-019 PARITY (only when PARITY_EN=1) SHALL drive XOR of the 8 data bits, inverted when PARITY_ODD=1, for CLKS_PER_BIT cycles.
REQ-020 STOP SHALL drive tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-021 A per-bit cycle counter SHALL count 0..CLKS_PER_BIT-1, clear at each bit boundary, and never wrap mid-bit; a 3-bit index SHALL track data bits 0..7.
REQ-022 tx_done SHALL be 1 for exactly the first IDLE cycle after STOP, coincident with tx_ready=1.
REQ-023 With tx_valid held high, the next handshake SHALL occur on that same first IDLE cycle; frames are separated by exactly one extra mark cycle.
REQ-024 Total frame time, handshake edge to tx_done, SHALL be (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT+1 cycles.
REQ-025 Illegal or unreachable state encodings SHALL return to IDLE with tx_out=1 on the next edge.

Reset
REQ-026 RST=1 SHALL immediately, without a clock edge, force IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, and clear the counters and shift register.
REQ-027 Reset mid-frame SHALL abort the frame with no tx_done and no resumption; the first handshake after release SHALL send a complete new frame.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-028 Send 0xA5, PARITY_EN=0 -> tx_out = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; tx_done 41 cycles after handshake.
REQ-029 Send 0xA5 with PARITY_EN=1, even parity -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; STOP_BITS=2 gives 8 stop cycles.
REQ-030 tx_valid held high with 0x00 then 0xFF -> second handshake on the tx_done cycle; exactly 5 mark cycles (4 stop + 1 idle) between frames.
REQ-031 Pulse tx_valid with 0x3C while busy -> ignored: exactly one frame is sent and tx_data changes do not corrupt it.
REQ-032 Assert RST during data bit 3 -> tx_out=1 asynchronously, tx_ready=1, no tx_done; the next send of 0x81 produces a correct frame.
REQ-033 CLKS_PER_BIT=2 boundary -> every bit lasts exactly 2 cycles and the frame length matches REQ-024.
